// File: rtl/z_transition_logger_if.sv
// Event drain port of z_transition_logger: head entry plus valid/ready handshake.
interface z_transition_logger_if #(
    parameter int CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W+3:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/z_transition_logger.sv
// Logs changes of controller code z as {prev, new, dwell} into a FWFT FIFO; event visible right after the sampling edge,
// dropped (sticky overflow) only when full with no pop on that edge. ZLOG_DROP_CNT_EN enables the saturating drop counter.
module z_transition_logger #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               z,
    z_transition_logger_if.master    out_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = CNT_W + 4;

    logic [1:0]       z_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q;

    logic evt, pop, push, drop, full;

    always_comb begin
        evt  = (z != z_q);
        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && out_if.out_ready;
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        push = evt && (!full || pop);
        drop = evt && full && !pop;

        dwell_d = dwell_q;
        if (evt)
            dwell_d = '0;
        else if (dwell_q != '1)
            dwell_d = dwell_q + CNT_W'(1);

        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q        <= 2'b00;
            dwell_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            z_q     <= z;
            dwell_q <= dwell_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {z_q, z, dwell_q};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (drop)
                overflow_q <= 1'b1;
        end
    end

`ifdef ZLOG_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt_q <= 8'd0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

    assign out_if.out_valid = (level_q != '0);
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign level            = level_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_z_transition_logger.sv
// Directed bench for z_transition_logger (CNT_W=8, DEPTH=4); expected drop_cnt follows ZLOG_DROP_CNT_EN.
module tb_z_transition_logger;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] z = 2'b00;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ZLOG_DROP_CNT_EN
    localparam logic [7:0] EXP_DROPS = 8'd2;
`else
    localparam logic [7:0] EXP_DROPS = 8'd0;
`endif

    z_transition_logger_if #(.CNT_W(8)) zif ();

    z_transition_logger #(.CNT_W(8), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .z        (z),
        .out_if   (zif),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        z = 2'b00;
        zif.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [11:0] ev(input logic [1:0] p, input logic [1:0] n, input logic [7:0] d);
        return {p, n, d};
    endfunction

    initial begin
        zif.out_ready = 1'b0;

        // Reset state
        tick();
        check("rst_valid",    zif.out_valid, 0);
        check("rst_level",    level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dropcnt",  drop_cnt, 0);
        check("rst_data",     zif.out_data, 0);
        reset = 1'b0;

        // Hold 00 for 5 edges then 01
        repeat (5) tick();
        check("hold_no_event", level, 0);
        z = 2'b01;
        tick();
        check("first_level", level, 1);
        check("first_valid", zif.out_valid, 1);
        check("first_data",  zif.out_data, ev(2'b00, 2'b01, 8'd5));

        // Sequence 00 (2 edges) -> 01 -> 00 -> 10, no consumer
        do_reset();
        repeat (2) tick();
        z = 2'b01; tick();
        z = 2'b00; tick();
        z = 2'b10; tick();
        check("seq_level", level, 3);
        check("seq_e0", zif.out_data, ev(2'b00, 2'b01, 8'd2));
        zif.out_ready = 1'b1; tick();
        check("seq_level_pop1", level, 2);
        check("seq_e1", zif.out_data, ev(2'b01, 2'b00, 8'd0));
        tick();
        check("seq_e2", zif.out_data, ev(2'b00, 2'b10, 8'd0));
        tick();
        check("seq_empty_valid", zif.out_valid, 0);
        tick();
        check("seq_empty_ready_level", level, 0);
        zif.out_ready = 1'b0;

        // Overflow: 4 events fill, 2 more are dropped
        do_reset();
        z = 2'b01; tick();
        z = 2'b00; tick();
        z = 2'b01; tick();
        z = 2'b00; tick();
        check("fill_level", level, 4);
        check("fill_no_overflow", overflow, 0);
        z = 2'b01; tick();
        z = 2'b00; tick();
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_dropcnt", drop_cnt, EXP_DROPS);
        zif.out_ready = 1'b1;
        check("ovf_e0", zif.out_data, ev(2'b00, 2'b01, 8'd0)); tick();
        check("ovf_e1", zif.out_data, ev(2'b01, 2'b00, 8'd0)); tick();
        check("ovf_e2", zif.out_data, ev(2'b00, 2'b01, 8'd0)); tick();
        check("ovf_e3", zif.out_data, ev(2'b01, 2'b00, 8'd0)); tick();
        check("ovf_drained", level, 0);
        check("ovf_sticky", overflow, 1);
        zif.out_ready = 1'b0;

        // Full FIFO with simultaneous pop and push
        do_reset();
        z = 2'b01; tick();
        z = 2'b00; tick();
        z = 2'b01; tick();
        z = 2'b00; tick();
        zif.out_ready = 1'b1;
        z = 2'b10; tick();
        zif.out_ready = 1'b0;
        check("pp_level", level, 4);
        check("pp_overflow", overflow, 0);
        check("pp_dropcnt", drop_cnt, 0);
        check("pp_head", zif.out_data, ev(2'b01, 2'b00, 8'd0));
        zif.out_ready = 1'b1;
        repeat (3) tick();
        check("pp_tail", zif.out_data, ev(2'b00, 2'b10, 8'd0));
        zif.out_ready = 1'b0;

        // Dwell saturation
        do_reset();
        zif.out_ready = 1'b1;
        z = 2'b10;
        repeat (301) tick();
        check("sat_drained", level, 0);
        zif.out_ready = 1'b0;
        z = 2'b00; tick();
        check("sat_level", level, 1);
        check("sat_data", zif.out_data, ev(2'b10, 2'b00, 8'd255));

        // Asynchronous reset with level 2 and overflow set
        do_reset();
        z = 2'b01; tick();
        z = 2'b00; tick();
        z = 2'b01; tick();
        z = 2'b00; tick();
        z = 2'b01; tick();
        zif.out_ready = 1'b1; repeat (2) tick();
        zif.out_ready = 1'b0;
        check("ar_pre_level", level, 2);
        check("ar_pre_ovf", overflow, 1);
        #2;
        reset = 1'b1;
        z = 2'b00;
        #1;
        check("ar_valid", zif.out_valid, 0);
        check("ar_level", level, 0);
        check("ar_overflow", overflow, 0);
        check("ar_dropcnt", drop_cnt, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("ar_post_level", level, 0);
        check("ar_post_valid", zif.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/z_transition_logger.md
# z_transition_logger

Downstream consumer of the two-bit Moore controller output `z`. It samples `z` every clock and detects code changes. For each change it records an event of {previous code, new code, dwell length} in a small first-word-fall-through FIFO. Events drain through a valid/ready port toward the status/debug bus, so software can reconstruct the controller's state history without polling every cycle.

## Interface
- `CNT_W`, default 8: width of the dwell counter (cycles a code was held); range 2..16.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `z`, in, 2: controller output code (00 = A, 01 = B, 10 = C; 11 is accepted as an ordinary code).
- `out_valid`, out, 1: head entry present.
- `out_ready`, in, 1: consumer accepts head entry.
- `out_data`, out, CNT_W+4: {prev_z[1:0], new_z[1:0], dwell[CNT_W-1:0]}, MSB first.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky; set when an event is dropped.
- `drop_cnt`, out, 8: saturating count of dropped events (see Configuration).

## Operation
Tracking state:
- `z_q` is the last accepted code; reset value 2'b00, matching the controller's reset state A.
- `dwell` reset value is 0.

Per rising edge, when `z == z_q`:
- `dwell <= dwell + 1`, saturating at 2^CNT_W−1.
- No event is generated.

Per rising edge, when `z != z_q`:
- Generate event {z_q, z, dwell}.
- `z_q <= z`, `dwell <= 0`.
- `dwell` therefore equals the number of edges at which the old code was re-sampled unchanged.

FIFO behaviour:
- Circular buffer with read and write pointers and an occupancy counter.
- Pop occurs on an edge with `out_valid && out_ready`.
- Push occurs on an edge with an event when `level < DEPTH`.
- Push also occurs when `level == DEPTH` and a pop happens on the same edge.
- Simultaneous push and pop leaves `level` unchanged; pointers wrap modulo DEPTH.

Full with no pop:
- The event is dropped and `overflow <= 1`.
- `z_q` and `dwell` still update as normal, so tracking never stalls.

Output and control:
- `out_data` is the head entry whenever `out_valid = 1`; it holds its last value (don't-care) when empty.
- `out_valid = (level != 0)`.
- Asserting `out_ready` while empty has no effect.
- `overflow` is cleared only by `reset`.

Reset values of all outputs:
- `out_valid` = 0, `out_data` = 0, `level` = 0, `overflow` = 0, `drop_cnt` = 0.

Reset mid-operation:
- Pending entries are discarded and pointers are zeroed.
- `z_q` returns to 00 and `dwell` to 0.
- The first edge after reset release compares against 00.

## Timing
- Event latency: a change of `z` sampled at edge N produces `out_valid = 1` and `level` incremented immediately after edge N.
- Back-to-back changes on consecutive edges each generate an event; dwell is 0 for a code held one edge.
- Throughput: one push and one pop per cycle sustained.
- `out_data` and `out_valid` are registered outputs (driven from FIFO storage and the occupancy counter); there is no combinational path from `z` or `out_ready`.
- `out_ready` may toggle freely. The consumer must not assume that `out_valid` stays high after a pop.

## Configuration
- Macro `ZLOG_DROP_CNT_EN`.
- Defined: `drop_cnt` increments by 1 on every dropped event, saturating at 255, and is cleared by `reset`.
- Undefined: the counter logic is not compiled and `drop_cnt` is tied to 8'd0. `overflow` behaves identically in both builds.

## Test plan
- Reset, hold `z` = 00 for 5 edges, then `z` = 01 → one event, `out_data` = {00, 01, 5}, `level` = 1, `out_valid` = 1.
- With `out_ready` = 0: sequence 00→01→00→10, one edge each → `level` = 3; entries in order {00,01,k}, {01,00,0}, {00,10,0}.
- Fill DEPTH = 4 with `out_ready` = 0, then cause 2 more changes → `level` = 4, `overflow` = 1, `drop_cnt` = 2 (with macro) or 0 (without); the FIFO contents are the first 4 events.
- Full FIFO, event and `out_ready` = 1 on the same edge → pop and push both occur; `level` stays 4 and `overflow` stays 0.
- Hold `z` = 10 for 300 edges with CNT_W = 8, then change to 00 → dwell = 255 (saturated).
- Assert `reset` asynchronously between edges with `level` = 2 → `out_valid`, `level`, `overflow` and `drop_cnt` go to 0 without a clock edge; after release, `z` = 00 generates no event.
